// File: rtl/oled_i2c_arbiter_if.sv
// Bus bundle between the per-panel sequencers, the arbiter and the shared I2C master.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface oled_i2c_arbiter_if #(
   parameter int unsigned NUM_REQ = 2
);
   logic [NUM_REQ-1:0]   req;
   logic [NUM_REQ-1:0]   gnt;
   logic [7*NUM_REQ-1:0] req_cmd_address;
   logic [NUM_REQ-1:0]   req_cmd_start;
   logic [NUM_REQ-1:0]   req_cmd_write_multiple;
   logic [NUM_REQ-1:0]   req_cmd_stop;
   logic [NUM_REQ-1:0]   req_cmd_valid;
   logic [NUM_REQ-1:0]   req_cmd_ready;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_data_valid;
   logic [NUM_REQ-1:0]   req_data_last;
   logic [NUM_REQ-1:0]   req_data_ready;
   logic [6:0]           m_cmd_address;
   logic                 m_cmd_start;
   logic                 m_cmd_write_multiple;
   logic                 m_cmd_stop;
   logic                 m_cmd_valid;
   logic                 m_cmd_ready;
   logic [7:0]           m_data;
   logic                 m_data_valid;
   logic                 m_data_last;
   logic                 m_data_ready;
   logic                 m_busy;

   modport slave (
      input  req, req_cmd_address, req_cmd_start, req_cmd_write_multiple, req_cmd_stop,
             req_cmd_valid, req_data, req_data_valid, req_data_last,
             m_cmd_ready, m_data_ready, m_busy,
      output gnt, req_cmd_ready, req_data_ready,
             m_cmd_address, m_cmd_start, m_cmd_write_multiple, m_cmd_stop, m_cmd_valid,
             m_data, m_data_valid, m_data_last
   );

   modport master (
      output req, req_cmd_address, req_cmd_start, req_cmd_write_multiple, req_cmd_stop,
             req_cmd_valid, req_data, req_data_valid, req_data_last,
             m_cmd_ready, m_data_ready, m_busy,
      input  gnt, req_cmd_ready, req_data_ready,
             m_cmd_address, m_cmd_start, m_cmd_write_multiple, m_cmd_stop, m_cmd_valid,
             m_data, m_data_valid, m_data_last
   );
endinterface

// File: rtl/oled_i2c_arbiter.sv
// Round-robin arbiter sharing one byte-stream I2C master between NUM_REQ OLED sequencers.
// Optional stall watchdog enabled by defining OLED_ARB_WATCHDOG_EN.
module oled_i2c_arbiter #(
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned GAP_CYCLES = 1000,
   parameter int unsigned WDT_CYCLES = 65535
) (
   input  logic              clk,
   input  logic              rst_n,
   oled_i2c_arbiter_if.slave bus,
   output logic [1:0]        owner,
   output logic              arb_idle,
   output logic              wdt_abort
);
   typedef enum logic [2:0] {IDLE, GRANT, XFER, DRAIN, GAP} state_e;

   state_e               state_q, state_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [1:0]           owner_q, owner_d;
   logic [1:0]           rr_q, rr_d;
   logic [31:0]          gap_cnt_q, gap_cnt_d;
   logic                 cmd_hs, data_hs, last_hs, req_held, any_req, wdt_fire;
   logic [1:0]           win;

   // gnt is one-hot, so the last matching iteration is the only one.
   always_comb begin
      bus.m_cmd_address        = '0;
      bus.m_cmd_start          = 1'b0;
      bus.m_cmd_write_multiple = 1'b0;
      bus.m_cmd_stop           = 1'b0;
      bus.m_cmd_valid          = 1'b0;
      bus.m_data               = '0;
      bus.m_data_valid         = 1'b0;
      bus.m_data_last          = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt_q[i]) begin
            bus.m_cmd_address        = bus.req_cmd_address[7*i +: 7];
            bus.m_cmd_start          = bus.req_cmd_start[i];
            bus.m_cmd_write_multiple = bus.req_cmd_write_multiple[i];
            bus.m_cmd_stop           = bus.req_cmd_stop[i];
            bus.m_cmd_valid          = bus.req_cmd_valid[i];
            bus.m_data               = bus.req_data[8*i +: 8];
            bus.m_data_valid         = bus.req_data_valid[i];
            bus.m_data_last          = bus.req_data_last[i];
         end
      end
   end

   assign bus.req_cmd_ready  = gnt_q & {NUM_REQ{bus.m_cmd_ready}};
   assign bus.req_data_ready = gnt_q & {NUM_REQ{bus.m_data_ready}};
   assign bus.gnt            = gnt_q;
   assign owner              = owner_q;
   assign arb_idle           = (state_q == IDLE);

   assign cmd_hs   = bus.m_cmd_valid & bus.m_cmd_ready;
   assign data_hs  = bus.m_data_valid & bus.m_data_ready;
   assign last_hs  = data_hs & bus.m_data_last;
   assign req_held = |(bus.req & gnt_q);
   assign any_req  = |bus.req;

   // First requester at or after rr_q, wrapping modulo NUM_REQ.
   always_comb begin
      int unsigned        j;
      logic               found;
      logic [NUM_REQ-1:0] req_rot;
      win   = rr_q;
      found = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         j = 32'(rr_q) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         req_rot = bus.req >> j;
         if (!found && req_rot[0]) begin
            found = 1'b1;
            win   = j[1:0];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      owner_d   = owner_q;
      rr_d      = rr_q;
      gap_cnt_d = gap_cnt_q;
      unique case (state_q)
         IDLE: if (any_req) begin
            gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
            owner_d = win;
            rr_d    = (win == 2'(NUM_REQ - 1)) ? 2'd0 : win + 2'd1;
            state_d = GRANT;
         end
         GRANT: if (cmd_hs) begin
            if (bus.m_cmd_write_multiple) begin
               state_d = XFER;
            end else if (bus.m_cmd_stop) begin
               state_d = DRAIN;
               gnt_d   = '0;
            end
         end else if (!req_held) begin
            state_d = IDLE;
            gnt_d   = '0;
         end
         XFER: if (last_hs) begin
            state_d = DRAIN;
            gnt_d   = '0;
         end
         DRAIN: if (!bus.m_busy) begin
            gap_cnt_d = '0;
            state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
         end
         GAP: begin
            if (gap_cnt_q == GAP_CYCLES - 1) state_d = IDLE;
            else                             gap_cnt_d = gap_cnt_q + 32'd1;
         end
         default: state_d = IDLE;
      endcase
      if (wdt_fire) begin
         state_d = DRAIN;
         gnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         owner_q   <= '0;
         rr_q      <= '0;
         gap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         owner_q   <= owner_d;
         rr_q      <= rr_d;
         gap_cnt_q <= gap_cnt_d;
      end
   end

`ifdef OLED_ARB_WATCHDOG_EN
   logic [31:0] wdt_cnt_q, wdt_cnt_d;
   logic        wdt_abort_q, wdt_abort_d;

   // Counts consecutive handshake-free cycles while the bus is owned.
   always_comb begin
      wdt_cnt_d   = '0;
      wdt_fire    = 1'b0;
      if ((state_q == GRANT || state_q == XFER) && !(cmd_hs || data_hs)) begin
         if (wdt_cnt_q == WDT_CYCLES - 1) wdt_fire = 1'b1;
         else                             wdt_cnt_d = wdt_cnt_q + 32'd1;
      end
      wdt_abort_d = wdt_fire;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdt_cnt_q   <= '0;
         wdt_abort_q <= 1'b0;
      end else begin
         wdt_cnt_q   <= wdt_cnt_d;
         wdt_abort_q <= wdt_abort_d;
      end
   end

   assign wdt_abort = wdt_abort_q;
`else
   assign wdt_fire  = 1'b0;
   // WDT_CYCLES has no effect without the watchdog; referenced so the port list stays uniform.
   assign wdt_abort = 1'b0 & (WDT_CYCLES != 0);
`endif
endmodule

// File: tb/tb_oled_i2c_arbiter.sv
// Self-checking bench for oled_i2c_arbiter: directed test-plan scenarios plus random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_oled_i2c_arbiter;
   localparam int N   = 2;
   localparam int GAP = 4;
   localparam int WDT = 16;
`ifdef OLED_ARB_WATCHDOG_EN
   localparam bit WDT_ON = 1'b1;
`else
   localparam bit WDT_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] owner;
   logic       arb_idle;
   logic       wdt_abort;
   int         tests = 0;
   int         fails = 0;

   oled_i2c_arbiter_if #(.NUM_REQ(N)) bus ();

   oled_i2c_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP), .WDT_CYCLES(WDT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .owner     (owner),
      .arb_idle  (arb_idle),
      .wdt_abort (wdt_abort)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: which requester owns the bus, whether we wait for the master,
   // and how many gap cycles remain before a new contest.
   int md_cur   = -1;
   bit md_xfer  = 0;
   bit md_drain = 0;
   int md_gap   = 0;
   int md_rr    = 0;
   int md_owner = 0;
   int md_wdt   = 0;
   bit md_abort = 0;

   task automatic release_to_drain();
      md_cur   = -1;
      md_xfer  = 0;
      md_drain = 1;
   endtask

   task automatic model_step();
      bit c_hs, d_hs, l_hs;
      md_abort = 0;
      if (md_cur >= 0) begin
         c_hs = bus.req_cmd_valid[md_cur] && bus.m_cmd_ready;
         d_hs = bus.req_data_valid[md_cur] && bus.m_data_ready;
         l_hs = d_hs && bus.req_data_last[md_cur];
         md_wdt = (c_hs || d_hs) ? 0 : md_wdt + 1;
         if (WDT_ON && md_wdt == WDT) begin
            md_abort = 1;
            release_to_drain();
         end else if (!md_xfer) begin
            if (c_hs) begin
               if (bus.req_cmd_write_multiple[md_cur]) md_xfer = 1;
               else if (bus.req_cmd_stop[md_cur]) release_to_drain();
            end else if (!bus.req[md_cur]) begin
               md_cur = -1;
            end
         end else if (l_hs) begin
            release_to_drain();
         end
      end else if (md_drain) begin
         if (!bus.m_busy) begin
            md_drain = 0;
            md_gap   = GAP;
         end
      end else if (md_gap > 0) begin
         md_gap--;
      end else begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (md_rr + k) % N;
            if (bus.req[j]) begin
               md_cur   = j;
               md_owner = j;
               md_rr    = (j + 1) % N;
               md_xfer  = 0;
               md_wdt   = 0;
               break;
            end
         end
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         md_cur = -1; md_xfer = 0; md_drain = 0; md_gap = 0;
         md_rr = 0; md_owner = 0; md_wdt = 0; md_abort = 0;
      end else begin
         model_step();
      end
   end

   always @(negedge clk) begin
      logic [N-1:0] eg;
      logic [10:0]  ecmd;
      logic [9:0]   edat;
      if (rst_n) begin
         eg   = '0;
         ecmd = '0;
         edat = '0;
         if (md_cur >= 0) begin
            eg   = {{(N-1){1'b0}}, 1'b1} << md_cur;
            ecmd = {bus.req_cmd_valid[md_cur], bus.req_cmd_address[7*md_cur +: 7],
                    bus.req_cmd_start[md_cur], bus.req_cmd_write_multiple[md_cur],
                    bus.req_cmd_stop[md_cur]};
            edat = {bus.req_data_valid[md_cur], bus.req_data[8*md_cur +: 8],
                    bus.req_data_last[md_cur]};
         end
         chk("gnt", 32'(bus.gnt), 32'(eg));
         chk("owner", 32'(owner), 32'(md_owner));
         chk("arb_idle", 32'(arb_idle), 32'(md_cur < 0 && !md_drain && md_gap == 0));
         chk("wdt_abort", 32'(wdt_abort), 32'(md_abort));
         chk("m_cmd", 32'({bus.m_cmd_valid, bus.m_cmd_address, bus.m_cmd_start,
                           bus.m_cmd_write_multiple, bus.m_cmd_stop}), 32'(ecmd));
         chk("m_data", 32'({bus.m_data_valid, bus.m_data, bus.m_data_last}), 32'(edat));
         chk("req_ready", 32'({bus.req_cmd_ready, bus.req_data_ready}),
             32'({eg & {N{bus.m_cmd_ready}}, eg & {N{bus.m_data_ready}}}));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.req = '0; bus.req_cmd_address = '0; bus.req_cmd_start = '0;
      bus.req_cmd_write_multiple = '0; bus.req_cmd_stop = '0; bus.req_cmd_valid = '0;
      bus.req_data = '0; bus.req_data_valid = '0; bus.req_data_last = '0;
      bus.m_cmd_ready = 1'b0; bus.m_data_ready = 1'b0; bus.m_busy = 1'b0;
   endtask

   task automatic do_reset();
      cyc();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) cyc();
      rst_n = 1'b1;
   endtask

   logic [7:0] t1_bytes [3] = '{8'hA5, 8'h00, 8'hFF};
   int         n;
   int         ord [3];
   int         cnt;
   logic [N-1:0] prev_g;

   initial begin
      clear_inputs();
      do_reset();
      @(negedge clk);
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_idle", 32'(arb_idle), 32'd1);
      chk("rst_owner", 32'(owner), 32'd0);
      chk("rst_mvalid", 32'({bus.m_cmd_valid, bus.m_data_valid}), 32'd0);

      // single-panel write of three bytes, then drain and gap
      cyc();
      bus.req = 2'b01; bus.req_cmd_address[6:0] = 7'h3C; bus.req_cmd_write_multiple[0] = 1'b1;
      bus.req_cmd_start[0] = 1'b1; bus.req_cmd_valid[0] = 1'b1;
      bus.m_cmd_ready = 1'b1; bus.m_data_ready = 1'b1; bus.m_busy = 1'b1;
      @(negedge clk);
      chk("t1_gnt_before", 32'(bus.gnt), 32'd0);
      cyc();
      @(negedge clk);
      chk("t1_gnt_after", 32'(bus.gnt), 32'h1);
      chk("t1_addr", 32'(bus.m_cmd_address), 32'h3C);
      cyc();
      bus.req_cmd_valid = '0; bus.req = '0;
      for (int b = 0; b < 3; b++) begin
         bus.req_data[7:0] = t1_bytes[b]; bus.req_data_valid[0] = 1'b1; bus.req_data_last[0] = (b == 2);
         @(negedge clk);
         chk("t1_byte", 32'(bus.m_data), 32'(t1_bytes[b]));
         chk("t1_byte_last", 32'(bus.m_data_last), 32'(b == 2));
         cyc();
      end
      bus.req_data_valid = '0; bus.req_data_last = '0;
      @(negedge clk);
      chk("t1_drain_gnt", 32'(bus.gnt), 32'd0);
      cyc(); cyc();
      bus.m_busy = 1'b0;
      cyc();
      n = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (arb_idle) break;
         n++;
         cyc();
      end
      chk("t1_gap_len", 32'(n), 32'd4);

      // both requesting: round-robin order 0,1,0
      do_reset();
      bus.req = 2'b11; bus.req_cmd_address = {7'h3D, 7'h3C}; bus.req_cmd_write_multiple = 2'b11;
      bus.req_cmd_valid = 2'b11; bus.req_data = 16'hB2A1; bus.req_data_valid = 2'b11;
      bus.req_data_last = 2'b11; bus.m_cmd_ready = 1'b1; bus.m_data_ready = 1'b1;
      cnt = 0; prev_g = '0;
      for (int k = 0; k < 100 && cnt < 3; k++) begin
         @(negedge clk);
         if (bus.gnt != 0 && prev_g == 0) begin
            ord[cnt] = int'(owner);
            cnt++;
         end
         prev_g = bus.gnt;
      end
      chk("t2_count", 32'(cnt), 32'd3);
      chk("t2_order0", 32'(ord[0]), 32'd0);
      chk("t2_order1", 32'(ord[1]), 32'd1);
      chk("t2_order2", 32'(ord[2]), 32'd0);

      // req0 arrives while req1 is mid-transfer
      do_reset();
      bus.req = 2'b10; bus.req_cmd_address = {7'h3D, 7'h3C}; bus.req_cmd_write_multiple = 2'b11;
      bus.req_cmd_valid = 2'b10; bus.m_cmd_ready = 1'b1; bus.m_data_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.gnt == 2'b10) break;
      end
      chk("t3_gnt1", 32'(bus.gnt), 32'h2);
      cyc();
      bus.req_cmd_valid = '0; bus.req[0] = 1'b1; bus.req_data_valid[1] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         bus.req_data_valid[0] = k[0]; bus.req_data[15:8] = 8'(k + 8'h40); bus.req_data_last[1] = (k == 4);
         @(negedge clk);
         chk("t3_rdy0", 32'(bus.req_data_ready[0]), 32'd0);
         chk("t3_hold", 32'(bus.gnt), 32'h2);
         cyc();
      end
      bus.req[1] = 1'b0; bus.req_data_valid = '0; bus.req_data_last = '0;
      n = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.gnt != 0) break;
         n++;
         cyc();
      end
      chk("t3_wait", 32'(n), 32'd6);
      chk("t3_gnt0", 32'(bus.gnt), 32'h1);

      // granted requester withdraws before any command
      do_reset();
      bus.req = 2'b11;
      cyc();
      @(negedge clk);
      chk("t4_gnt0", 32'(bus.gnt), 32'h1);
      bus.req = 2'b10;
      @(negedge clk);
      chk("t4_idle_gnt", 32'(bus.gnt), 32'd0);
      chk("t4_idle", 32'(arb_idle), 32'd1);
      @(negedge clk);
      chk("t4_gnt1", 32'(bus.gnt), 32'h2);
      chk("t4_owner", 32'(owner), 32'd1);
      chk("t4_model", 32'(md_cur), 32'd1);

      // stalled sequencer after its command
      do_reset();
      bus.req = 2'b01; bus.req_cmd_write_multiple[0] = 1'b1; bus.req_cmd_valid[0] = 1'b1;
      bus.m_cmd_ready = 1'b1; bus.m_data_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.gnt == 2'b01) break;
      end
      cyc();
      bus.req_cmd_valid = '0;
`ifdef OLED_ARB_WATCHDOG_EN
      n = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (wdt_abort) break;
         cyc();
         n++;
      end
      chk("t5_wdt_cycles", 32'(n), 32'd16);
      chk("t5_wdt_gnt", 32'(bus.gnt), 32'd0);
      cyc();
      @(negedge clk);
      chk("t5_wdt_pulse", 32'(wdt_abort), 32'd0);
`else
      repeat (1000) cyc();
      @(negedge clk);
      chk("t5_hold_gnt", 32'(bus.gnt), 32'h1);
      chk("t5_no_abort", 32'(wdt_abort), 32'd0);
`endif

      // asynchronous reset in the middle of a transfer
      do_reset();
      bus.req = 2'b10; bus.req_cmd_write_multiple = 2'b11; bus.req_cmd_valid = 2'b10;
      bus.m_cmd_ready = 1'b1; bus.m_data_ready = 1'b1;
      repeat (3) cyc();
      bus.req_data_valid = 2'b10;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6_gnt", 32'(bus.gnt), 32'd0);
      chk("t6_owner", 32'(owner), 32'd0);
      chk("t6_mvalid", 32'({bus.m_cmd_valid, bus.m_data_valid}), 32'd0);
      chk("t6_idle", 32'(arb_idle), 32'd1);
      cyc();
      rst_n = 1'b1;

      // random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         cyc();
         for (int i = 0; i < N; i++) begin
            bus.req[i]                    = ($urandom_range(0, 9) < 8);
            bus.req_cmd_start[i]          = $urandom_range(0, 1) == 1;
            bus.req_cmd_write_multiple[i] = $urandom_range(0, 1) == 1;
            bus.req_cmd_stop[i]           = $urandom_range(0, 1) == 1;
            bus.req_cmd_valid[i]          = $urandom_range(0, 1) == 1;
            bus.req_data_valid[i]         = ($urandom_range(0, 9) < 6);
            bus.req_data_last[i]          = ($urandom_range(0, 3) == 0);
         end
         bus.req_cmd_address = (7*N)'($urandom);
         bus.req_data        = (8*N)'($urandom);
         bus.m_cmd_ready     = ($urandom_range(0, 9) < 7);
         bus.m_data_ready    = ($urandom_range(0, 9) < 7);
         bus.m_busy          = ($urandom_range(0, 9) < 4);
      end
      cyc();
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
